// File: rtl/pq_pkg.sv
// Shared types for the priority-queue command driver: command opcodes,
// response status codes and the driver FSM state encoding.
package pq_pkg;

  typedef enum logic [1:0] {
    OP_ENQUEUE = 2'd0,
    OP_DEQUEUE = 2'd1,
    OP_REPLACE = 2'd2,
    OP_PEEK    = 2'd3
  } pq_op_e;

  typedef enum logic [1:0] {
    STAT_OK           = 2'd0,
    STAT_FULL_REJECT  = 2'd1,
    STAT_EMPTY_REJECT = 2'd2
  } pq_status_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } pq_state_e;

endpackage

// File: rtl/pq_cmd_driver.sv
// Turns one upstream command at a time into single-cycle strobes on an attached
// max-priority queue, waits for the queue to settle, then returns one response.
module pq_cmd_driver
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int QUEUE_SIZE    = 64,
  parameter int SETTLE_CYCLES = 5
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              i_cmd_valid,
  output logic                              o_cmd_ready,
  input  logic [1:0]                        i_cmd_op,
  input  logic [DATA_WIDTH-1:0]             i_cmd_data,
  output logic                              o_rsp_valid,
  input  logic                              i_rsp_ready,
  output logic [DATA_WIDTH-1:0]             o_rsp_data,
  output logic [1:0]                        o_rsp_status,
  output logic                              o_pq_wrt,
  output logic                              o_pq_read,
  output logic [DATA_WIDTH-1:0]             o_pq_data,
  input  logic                              i_pq_full,
  input  logic                              i_pq_empty,
  input  logic [DATA_WIDTH-1:0]             i_pq_data,
  output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_count,
  output logic [1:0]                        o_dbg_state
);

  localparam int CW = $clog2(QUEUE_SIZE + 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  pq_state_e             state_q, state_d;
  pq_op_e                op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [7:0]            settle_q, settle_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  pq_status_e            rsp_status_q, rsp_status_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  reject_full, reject_empty, pulse;

  // Handshakes: a command transfers on a rising edge where i_cmd_valid and
  // o_cmd_ready are both high; a response transfers on an edge where
  // o_rsp_valid and i_rsp_ready are both high. o_rsp_valid, once raised,
  // holds with stable data/status until it transfers.
  always_comb begin
    reject_full  = (op_q == OP_ENQUEUE) && i_pq_full;
    reject_empty = (op_q != OP_ENQUEUE) && i_pq_empty;
    pulse        = (state_q == ST_ISSUE) && !reject_full && !reject_empty
                   && (op_q != OP_PEEK);
  end

  assign o_pq_wrt     = pulse && ((op_q == OP_ENQUEUE) || (op_q == OP_REPLACE));
  assign o_pq_read    = pulse && ((op_q == OP_DEQUEUE) || (op_q == OP_REPLACE));
  assign o_pq_data    = data_q;
  assign o_cmd_ready  = (state_q == ST_IDLE) && !RST;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_status = rsp_status_q;
  assign o_count      = count_q;
  assign o_dbg_state  = state_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    data_d       = data_q;
    settle_d     = settle_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    count_d      = count_q;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          op_d    = pq_op_e'(i_cmd_op);
          data_d  = i_cmd_data;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Removed element (DEQUEUE/REPLACE) or current top (PEEK) is taken here.
        rsp_status_d = STAT_OK;
        rsp_data_d   = i_pq_data;
        if (pulse) begin
          settle_d = SETTLE_LAST;
          state_d  = ST_SETTLE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
          if (reject_full || reject_empty) begin
            rsp_status_d = reject_full ? STAT_FULL_REJECT : STAT_EMPTY_REJECT;
            rsp_data_d   = '0;
          end
        end
        if (o_pq_wrt && !o_pq_read && (count_q < CW'(QUEUE_SIZE))) begin
          count_d = count_q + CW'(1);
        end else if (o_pq_read && !o_pq_wrt && (count_q != '0)) begin
          count_d = count_q - CW'(1);
        end
      end
      ST_SETTLE: begin
        if (settle_q == 8'd0) begin
          // ENQUEUE reports the new top once the queue has settled.
          if (op_q == OP_ENQUEUE) rsp_data_d = i_pq_data;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_ENQUEUE;
      data_q       <= '0;
      settle_q     <= 8'd0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= STAT_OK;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      data_q       <= data_d;
      settle_q     <= settle_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      count_q      <= count_d;
    end
  end

endmodule
